// File: rtl/div_ratio_ctrl_pkg.sv
// Shared constants and types for the run-time clock-divider ratio controller.
package div_pkg;

  // Ratio select encodings seen on cfg_sel
  localparam logic [1:0] SEL_DIV9   = 2'd0;
  localparam logic [1:0] SEL_DIV12  = 2'd1;
  localparam logic [1:0] SEL_DIV80  = 2'd2;
  localparam logic [1:0] SEL_CUSTOM = 2'd3;

  // Fixed divide ratios offered by the controller
  localparam int RATIO_9  = 9;
  localparam int RATIO_12 = 12;
  localparam int RATIO_80 = 80;

  // Divider sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/div_ratio_ctrl_phase_counter.sv
// Phase counter for the divider: counts cycles within the current HIGH or
// LOW phase and flags the last cycle of that phase.
module div_phase_counter
  import div_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] phase_len,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Last cycle of a phase: cnt has reached phase_len-1
  assign tc = (cnt_q == (phase_len - W'(1)));

  // Restart at zero when the phase ends (or while idle), else count up
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear) begin
      cnt_d = '0;
    end
  end

  // Counter register, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Run-time ratio controller for the integer clock dividers. Produces a
// registered divided clock `out` and accepts ratio changes through a
// valid/ready handshake; a new ratio only takes effect at a period boundary
// (or straight away when idle), so `out` never shows a runt pulse.
module div_ratio_ctrl
  import div_pkg::*;
#(
  parameter int W           = 7,
  parameter int DEFAULT_SEL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_sel,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_err,
  output logic         out,
  output logic         period_done,
  output logic         busy,
  output logic [W-1:0] cur_ratio
);

  localparam logic [W-1:0] DEFAULT_RATIO =
    (DEFAULT_SEL == 0) ? W'(RATIO_9)  :
    (DEFAULT_SEL == 2) ? W'(RATIO_80) : W'(RATIO_12);

  // Map a select code (and custom value) onto an actual divide ratio
  function automatic logic [W-1:0] resolve_ratio(input logic [1:0]   sel,
                                                 input logic [W-1:0] div);
    logic [W-1:0] r;
    case (sel)
      SEL_DIV9:  r = W'(RATIO_9);
      SEL_DIV12: r = W'(RATIO_12);
      SEL_DIV80: r = W'(RATIO_80);
      default:   r = div;
    endcase
    return r;
  endfunction

  state_e       state_q, state_d;
  logic         out_q, out_d;
  logic [W-1:0] cur_ratio_q, cur_ratio_d;
  logic [W-1:0] pend_ratio_q, pend_ratio_d;
  logic         pend_q, pend_d;
  logic         cfg_err_q, cfg_err_d;

  logic [W-1:0] hi_len;
  logic [W-1:0] lo_len;
  logic [W-1:0] phase_len;
  logic         cnt_clear;
  logic         cnt_tc;
  logic         boundary;
  logic         accept;
  logic         apply;

  // HIGH gets the extra cycle on odd ratios: hi = ceil(N/2), lo = floor(N/2)
  assign lo_len    = cur_ratio_q >> 1;
  assign hi_len    = lo_len + {{(W-1){1'b0}}, cur_ratio_q[0]};
  assign phase_len = (state_q == LOW) ? lo_len : hi_len;

  // Counter restarts at every phase change and is held at zero when idle
  assign cnt_clear = (state_q == IDLE) || cnt_tc;
  assign boundary  = (state_q == LOW) && cnt_tc;

  div_phase_counter #(
    .W (W)
  ) u_phase_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .phase_len (phase_len),
    .tc        (cnt_tc)
  );

  // FSM state register, plus the registered divided output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next state: phases end on terminal count; en is only looked at in IDLE
  // and at the end of LOW, so dropping en never cuts a period short
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en) state_d = HIGH;
      HIGH: if (cnt_tc) state_d = LOW;
      LOW:  if (cnt_tc) state_d = en ? HIGH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: out is high exactly while the FSM sits in HIGH
  always_comb begin
    out_d = (state_d == HIGH);
  end

  // Handshake and ratio bookkeeping: apply a held ratio first, then accept
  // a new request (accept is only possible when nothing is held, so the two
  // never collide on the pending register)
  always_comb begin
    cur_ratio_d  = cur_ratio_q;
    pend_ratio_d = pend_ratio_q;
    pend_d       = pend_q;
    cfg_err_d    = 1'b0;
    accept       = cfg_valid && !pend_q;
    apply        = pend_q && ((state_q == IDLE) || boundary);
    if (apply) begin
      cur_ratio_d = pend_ratio_q;
      pend_d      = 1'b0;
    end
    if (accept) begin
      if ((cfg_sel == SEL_CUSTOM) && (cfg_div < W'(2))) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_d       = 1'b1;
        pend_ratio_d = resolve_ratio(cfg_sel, cfg_div);
      end
    end
  end

  // Ratio, pending-request and error-pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ratio_q  <= DEFAULT_RATIO;
      pend_ratio_q <= DEFAULT_RATIO;
      pend_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cur_ratio_q  <= cur_ratio_d;
      pend_ratio_q <= pend_ratio_d;
      pend_q       <= pend_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready   = !pend_q;
  assign cfg_err     = cfg_err_q;
  assign out         = out_q;
  assign period_done = boundary;
  assign busy        = (state_q != IDLE);
  assign cur_ratio   = cur_ratio_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl: a table of ratio-change requests
// applied in turn, plus hand-written multi-cycle sequences.
module tb_div_ratio_ctrl;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_sel;
  logic [W-1:0] cfg_div;
  logic         cfg_err;
  logic         out;
  logic         period_done;
  logic         busy;
  logic [W-1:0] cur_ratio;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_ratio_ctrl #(
    .W           (W),
    .DEFAULT_SEL (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_div     (cfg_div),
    .cfg_err     (cfg_err),
    .out         (out),
    .period_done (period_done),
    .busy        (busy),
    .cur_ratio   (cur_ratio)
  );

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] div;
    int           err;
    int           hi;
    int           lo;
    int           ratio;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until period_done is seen (bounded); checks it was reached
  task automatic wait_pd();
    int n;
    n = 0;
    while (period_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("wait_pd_reached", int'(period_done), 1);
  endtask

  // Measure one full period: high cycles, then low cycles up to and
  // including the period_done cycle. Returns positioned on that cycle.
  task automatic measure(output int hi, output int lo);
    int n;
    n  = 0;
    hi = 0;
    lo = 0;
    while (out !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    while (out === 1'b1 && n < 400) begin
      hi++;
      tick();
      n++;
    end
    while (period_done !== 1'b1 && n < 400) begin
      lo++;
      tick();
      n++;
    end
    lo++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached limit %0t", $time, 2_000_000);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, l, old;

    vecs[0] = '{2'd0, 7'd0,   0, 5,  4,  9};
    vecs[1] = '{2'd3, 7'd1,   1, 5,  4,  9};
    vecs[2] = '{2'd3, 7'd7,   0, 4,  3,  7};
    vecs[3] = '{2'd3, 7'd2,   0, 1,  1,  2};
    vecs[4] = '{2'd3, 7'd3,   0, 2,  1,  3};
    vecs[5] = '{2'd3, 7'd0,   1, 2,  1,  3};
    vecs[6] = '{2'd3, 7'd127, 0, 64, 63, 127};
    vecs[7] = '{2'd2, 7'd0,   0, 40, 40, 80};
    vecs[8] = '{2'd1, 7'd0,   0, 6,  6,  12};

    // ---- reset state ----
    rst       = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = 2'd0;
    cfg_div   = '0;
    repeat (3) tick();
    chk("rst_out", int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_ratio", int'(cur_ratio), 12);
    chk("rst_period_done", int'(period_done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);

    // ---- release with en=1, default ratio 12 ----
    rst = 1'b1;
    en  = 1'b1;
    chk("rel_cfg_ready", int'(cfg_ready), 1);
    chk("rel_out_before_en", int'(out), 0);
    tick();
    chk("first_rise_out", int'(out), 1);
    chk("first_rise_busy", int'(busy), 1);
    measure(h, l);
    chk("def_hi", h, 6);
    chk("def_lo", l, 6);
    chk("def_ratio", int'(cur_ratio), 12);

    // ---- table: request early in HIGH, takes effect next period ----
    for (int i = 0; i < 9; i++) begin
      old = int'(cur_ratio);
      tick();
      chk($sformatf("v%0d_ready_before", i), int'(cfg_ready), 1);
      cfg_valid = 1'b1;
      cfg_sel   = vecs[i].sel;
      cfg_div   = vecs[i].div;
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("v%0d_err", i), int'(cfg_err), vecs[i].err);
      chk($sformatf("v%0d_ready_after", i), int'(cfg_ready),
          (vecs[i].err != 0) ? 1 : 0);
      wait_pd();
      chk($sformatf("v%0d_ratio_hold", i), int'(cur_ratio), old);
      chk($sformatf("v%0d_err_cleared", i), int'(cfg_err), 0);
      measure(h, l);
      chk($sformatf("v%0d_hi", i), h, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), l, vecs[i].lo);
      chk($sformatf("v%0d_ratio", i), int'(cur_ratio), vecs[i].ratio);
      chk($sformatf("v%0d_ready_idle", i), int'(cfg_ready), 1);
    end

    // ---- back-to-back requests (div80 then div9), cfg_valid held ----
    tick();
    cfg_valid = 1'b1;
    cfg_sel   = 2'd2;
    tick();
    chk("bb_ready_low", int'(cfg_ready), 0);
    cfg_sel = 2'd0;
    wait_pd();
    chk("bb_ratio_hold", int'(cur_ratio), 12);
    chk("bb_ready_pd", int'(cfg_ready), 0);
    measure(h, l);
    chk("bb80_hi", h, 40);
    chk("bb80_lo", l, 40);
    chk("bb80_ratio", int'(cur_ratio), 80);
    chk("bb80_second_pending", int'(cfg_ready), 0);
    measure(h, l);
    chk("bb9_hi", h, 5);
    chk("bb9_lo", l, 4);
    chk("bb9_ratio", int'(cur_ratio), 9);
    cfg_valid = 1'b0;
    measure(h, l);
    chk("bb9b_hi", h, 5);
    chk("bb9b_lo", l, 4);
    chk("bb9b_ready", int'(cfg_ready), 1);

    // ---- request on the boundary cycle applies one period later ----
    cfg_valid = 1'b1;
    cfg_sel   = 2'd1;
    tick();
    cfg_valid = 1'b0;
    chk("edge_accepted", int'(cfg_ready), 0);
    chk("edge_not_applied", int'(cur_ratio), 9);
    measure(h, l);
    chk("edge_p1_hi", h, 5);
    chk("edge_p1_lo", l, 4);
    measure(h, l);
    chk("edge_p2_hi", h, 6);
    chk("edge_p2_lo", l, 6);
    chk("edge_p2_ratio", int'(cur_ratio), 12);

    // ---- en dropped 3 cycles into LOW at ratio 12 ----
    tick();
    repeat (5) tick();
    chk("endrop_last_high", int'(out), 1);
    repeat (3) tick();
    en = 1'b0;
    chk("endrop_low_out", int'(out), 0);
    tick();
    chk("endrop_c3_pd", int'(period_done), 0);
    chk("endrop_c3_busy", int'(busy), 1);
    tick();
    chk("endrop_c4_pd", int'(period_done), 0);
    tick();
    chk("endrop_c5_pd", int'(period_done), 1);
    chk("endrop_c5_out", int'(out), 0);
    tick();
    chk("endrop_idle_busy", int'(busy), 0);
    chk("endrop_idle_out", int'(out), 0);
    chk("endrop_idle_pd", int'(period_done), 0);
    repeat (3) tick();
    chk("endrop_stay_out", int'(out), 0);
    chk("endrop_stay_busy", int'(busy), 0);

    // request while idle applies on the following cycle
    cfg_valid = 1'b1;
    cfg_sel   = 2'd0;
    tick();
    cfg_valid = 1'b0;
    chk("idle_req_pending", int'(cfg_ready), 0);
    chk("idle_req_ratio_old", int'(cur_ratio), 12);
    tick();
    chk("idle_req_applied", int'(cur_ratio), 9);
    chk("idle_req_ready", int'(cfg_ready), 1);
    en = 1'b1;
    tick();
    chk("restart_out", int'(out), 1);
    measure(h, l);
    chk("restart_hi", h, 5);
    chk("restart_lo", l, 4);

    // ---- async reset mid-HIGH at ratio 80 with a request pending ----
    tick();
    cfg_valid = 1'b1;
    cfg_sel   = 2'd2;
    tick();
    cfg_valid = 1'b0;
    wait_pd();
    tick();
    chk("rst80_ratio", int'(cur_ratio), 80);
    cfg_valid = 1'b1;
    cfg_sel   = 2'd0;
    tick();
    cfg_valid = 1'b0;
    chk("rst80_pending", int'(cfg_ready), 0);
    repeat (5) tick();
    chk("rst80_high", int'(out), 1);
    #2;
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("arst_out", int'(out), 0);
    chk("arst_ratio", int'(cur_ratio), 12);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(cfg_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("arst_pend_cleared_ratio", int'(cur_ratio), 12);
    chk("arst_pend_cleared_ready", int'(cfg_ready), 1);
    chk("arst_idle_out", int'(out), 0);
    en = 1'b1;
    tick();
    chk("arst_restart_out", int'(out), 1);
    measure(h, l);
    chk("arst_hi", h, 6);
    chk("arst_lo", l, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
